// File: rtl/piso_serializer_if.sv
// Handshake bundle for the parallel-in/serial-out serializer.
// slave: the serializer itself. master: the producer and consumer side.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_bits;
  logic             io_out_valid;
  logic             io_out_ready;
  logic             io_out_bit;
  logic             io_out_last;
  logic             io_busy;

  modport slave (
    input  io_in_valid, io_in_bits, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bit, io_out_last, io_busy
  );

  modport master (
    output io_in_valid, io_in_bits, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bit, io_out_last, io_busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shift register with valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for a word; io_in_ready=1
// SHIFT | word in flight; one bit per accepted beat, io_out_last on the final bit
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic              clock,
  input logic              reset,
  piso_serializer_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             w_beat;
  logic             w_last;
  logic             w_load;

  assign w_load = (r_state == IDLE) && bus.io_in_valid;
  assign w_beat = (r_state == SHIFT) && bus.io_out_ready;
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.io_in_valid)  w_state_nxt = SHIFT;
      SHIFT:   if (w_beat && w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // shift register and bit counter; cleared on the last beat so IDLE always holds zeros
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_shift <= bus.io_in_bits;
      r_cnt   <= '0;
    end else if (w_beat) begin
      if (w_last) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else begin
        r_shift <= LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  // outputs depend only on registered state, never on the inputs
  always_comb begin
    bus.io_in_ready  = (r_state == IDLE);
    bus.io_out_valid = (r_state == SHIFT);
    bus.io_busy      = (r_state == SHIFT);
    bus.io_out_bit   = (r_state == SHIFT) &&
                       (LSB_FIRST ? r_shift[0] : r_shift[WIDTH-1]);
    bus.io_out_last  = (r_state == SHIFT) && w_last;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: unit 0 is LSB-first, unit 1 is MSB-first, both WIDTH=8.
module tb_piso_serializer;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;

  piso_serializer_if #(.WIDTH(8)) if_a ();
  piso_serializer_if #(.WIDTH(8)) if_b ();

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (if_a.slave)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (if_b.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {in_ready, out_valid, out_bit, out_last, busy}
  function automatic logic [4:0] outs(input int u);
    if (u == 0)
      return {if_a.io_in_ready, if_a.io_out_valid, if_a.io_out_bit, if_a.io_out_last, if_a.io_busy};
    else
      return {if_b.io_in_ready, if_b.io_out_valid, if_b.io_out_bit, if_b.io_out_last, if_b.io_busy};
  endfunction

  task automatic drive(input int u, input logic v, input logic [7:0] bits, input logic rdy);
    if (u == 0) begin
      if_a.io_in_valid = v; if_a.io_in_bits = bits; if_a.io_out_ready = rdy;
    end else begin
      if_b.io_in_valid = v; if_b.io_in_bits = bits; if_b.io_out_ready = rdy;
    end
  endtask

  // Checks bits first..last of word w, one per cycle, ready assumed high.
  task automatic stream(input int u, input string tag, input logic [7:0] w, input bit lsb,
                        input int first, input int last);
    logic [4:0] o;
    for (int i = first; i <= last; i++) begin
      o = outs(u);
      check({tag, " in_ready"}, 32'(o[4]), 32'd0);
      check({tag, " valid"},    32'(o[3]), 32'd1);
      check({tag, " bit"},      32'(o[2]), 32'(lsb ? w[i] : w[7-i]));
      check({tag, " last"},     32'(o[1]), 32'(i == 7));
      check({tag, " busy"},     32'(o[0]), 32'd1);
      @(negedge clock);
    end
  endtask

  task automatic expect_idle(input int u, input string tag);
    logic [4:0] o;
    o = outs(u);
    check({tag, " idle outs"}, 32'(o), 32'b10000);
  endtask

  task automatic load(input int u, input logic [7:0] w);
    drive(u, 1'b1, w, 1'b1);
    @(negedge clock);
    drive(u, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);

    // reset values
    #12;
    expect_idle(0, "reset a");
    expect_idle(1, "reset b");
    @(negedge clock);
    reset = 1'b1;

    // idle with io_out_ready toggling
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b0, 8'h00, k[0]);
      @(negedge clock);
      expect_idle(0, "idle toggle");
    end

    // 0xA5 LSB first, then io_in_ready back
    load(0, 8'hA5);
    stream(0, "a5", 8'hA5, 1'b1, 0, 7);
    expect_idle(0, "a5 after");

    // backpressure on 0x3C: stall on the 4th bit for 5 cycles
    load(0, 8'h3C);
    stream(0, "3c pre", 8'h3C, 1'b1, 0, 2);
    drive(0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check("3c stall bit",  32'(if_a.io_out_bit),   32'd1);
      check("3c stall last", 32'(if_a.io_out_last),  32'd0);
      check("3c stall vld",  32'(if_a.io_out_valid), 32'd1);
      @(negedge clock);
    end
    drive(0, 1'b0, 8'h00, 1'b1);
    stream(0, "3c post", 8'h3C, 1'b1, 3, 7);
    expect_idle(0, "3c after");

    // io_in_valid held and io_in_bits changed during SHIFT are ignored
    drive(0, 1'b1, 8'h5A, 1'b1);
    @(negedge clock);
    drive(0, 1'b1, 8'hFF, 1'b1);
    stream(0, "ign", 8'h5A, 1'b1, 0, 7);
    expect_idle(0, "ign gap");
    @(negedge clock);
    drive(0, 1'b0, 8'h00, 1'b1);
    stream(0, "ign next", 8'hFF, 1'b1, 0, 7);
    expect_idle(0, "ign after");

    // reset mid-word after the 4th bit of 0xFF
    load(0, 8'hFF);
    stream(0, "rst pre", 8'hFF, 1'b1, 0, 3);
    #2 reset = 1'b0;
    #1;
    expect_idle(0, "rst async");
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("rst no last", 32'(if_a.io_out_last), 32'd0);
    end
    reset = 1'b1;
    expect_idle(0, "rst release");
    load(0, 8'h01);
    stream(0, "post rst", 8'h01, 1'b1, 0, 7);
    expect_idle(0, "post rst after");

    // MSB-first unit
    load(1, 8'h81);
    stream(1, "81 msb", 8'h81, 1'b0, 0, 7);
    expect_idle(1, "81 after");
    load(1, 8'hC4);
    stream(1, "c4 msb", 8'hC4, 1'b0, 0, 7);
    expect_idle(1, "c4 after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
